// File: rtl/timer_sched_if.sv
// Bus between timer_sched and its requesters. The scheduler side uses the slave
// modport and the requester side uses the master modport.
interface timer_sched_if #(
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  localparam int NUM_REQ = 2**ID_W;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] load_val;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     abort;
  logic                     busy;
  logic [ID_W-1:0]          cur_id;
  logic [CNT_W-1:0]         count;

  modport master (
    output req, load_val,
    input  grant, done, abort, busy, cur_id, count
  );

  modport slave (
    input  req, load_val,
    output grant, done, abort, busy, cur_id, count
  );
endinterface

// File: rtl/timer_sched.sv
// Shares one down-counter timer among 2**ID_W requesters, round-robin by default.
// Define TIMER_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module timer_sched #(
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic         clk_in,
  input  logic         resetb,
  timer_sched_if.slave bus
);
  localparam int NUM_REQ = 2**ID_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_abort;
  logic [ID_W-1:0]    r_cur_id;
  logic [CNT_W-1:0]   r_count;

  logic [ID_W-1:0]    w_win;
  logic               w_any;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_cur_oh;

  assign w_any    = |bus.req;
  assign w_win_oh = NUM_REQ'(1) << w_win;
  assign w_cur_oh = NUM_REQ'(1) << r_cur_id;

`ifdef TIMER_SCHED_FIXED_PRIO_EN
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_win = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (bus.req[i]) w_win = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_idx;

  // Walk from farthest to nearest offset so the nearest set bit past rr_ptr wins.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_idx = r_rr_ptr + ID_W'(k);
      if (bus.req[w_idx]) w_win = w_idx;
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      r_rr_ptr <= '0;
    end else if (r_state == S_GAP) begin
      r_rr_ptr <= r_cur_id + ID_W'(1);
    end
  end
`endif

  always_ff @(posedge clk_in or negedge resetb) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetb) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_abort  <= 1'b0;
      r_cur_id <= '0;
      r_count  <= '0;
    end else begin
      r_done  <= '0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_win_oh;
            r_cur_id <= w_win;
            r_count  <= bus.load_val[w_win*CNT_W +: CNT_W];
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          // Withdrawal beats completion when both happen in the same cycle.
          if (!bus.req[r_cur_id]) begin
            r_abort <= 1'b1;
            r_grant <= '0;
            r_state <= S_GAP;
          end else if (r_count == '0) begin
            r_done  <= w_cur_oh;
            r_grant <= '0;
            r_state <= S_GAP;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant  = r_grant;
  assign bus.done   = r_done;
  assign bus.abort  = r_abort;
  assign bus.busy   = (r_state == S_RUN) || (r_state == S_GAP);
  assign bus.cur_id = r_cur_id;
  assign bus.count  = r_count;
endmodule
